// File: rtl/beat_click_generator.sv
// Metronome: tempo divider, beat scheduler and decaying square-wave click.
// Optional BEAT_ACCENT_EN gives the downbeat a full-scale click.
module beat_click_generator #(
    parameter int W             = 16,
    parameter int SAMPLE_FREQ   = 12000,
    parameter int CLICK_MS      = 20,
    parameter int MIN_BPM       = 30,
    parameter int MAX_BPM       = 300,
    parameter int BEATS_PER_BAR = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic [15:0]         bpm_in,
    input  logic                bpm_valid,
    output logic                bpm_ready,
    output logic                beat_pulse,
    output logic [3:0]          beat_count,
    output logic signed [W-1:0] click_sample,
    output logic                running
);
    localparam int CLICK_SAMPLES = SAMPLE_FREQ * CLICK_MS / 1000;
    localparam int KW = $clog2(CLICK_SAMPLES + 1);
    localparam logic [31:0] DIVIDEND = 32'(60 * SAMPLE_FREQ);
    localparam logic [W-1:0] AMP_LO = W'(1) << (W - 2);
`ifdef BEAT_ACCENT_EN
    localparam logic [W-1:0] AMP_HI = {1'b0, {(W - 1){1'b1}}};
`endif

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_PEND} div_t;
    typedef enum logic {STOPPED, RUNNING} main_t;

    div_t           div_q, div_d;
    main_t          main_q, main_d;
    logic           s1_q, s2_q, s3_q;
    logic [31:0]    dq_q, dq_d;
    logic [15:0]    rem_q, rem_d;
    logic [15:0]    dsr_q, dsr_d;
    logic [4:0]     dcnt_q, dcnt_d;
    logic [31:0]    res_q, res_d;
    logic [31:0]    ival_q, ival_d;
    logic [31:0]    scnt_q, scnt_d;
    logic [3:0]     nxt_q, nxt_d;
    logic [3:0]     bcnt_q, bcnt_d;
    logic           beat_q, beat_d;
    logic [W-1:0]   env_q, env_d;
    logic [W-1:0]   smp_q, smp_d;
    logic [KW-1:0]  kcnt_q, kcnt_d;
    logic           act_q, act_d;

    logic           tick, accept, stop, load, start, beat, commit;
    logic [15:0]    bpm_c;
    logic [16:0]    rem_sh;
    logic           ge;
    logic [15:0]    rem_n;
    logic [31:0]    dq_n;
    logic [31:0]    iv;
    logic [W-1:0]   amp, env_dec;
    logic [KW-1:0]  kn;

    assign tick   = s2_q & ~s3_q;
    assign accept = bpm_valid & bpm_ready;
    assign stop   = accept & (bpm_in == 16'd0);
    assign load   = accept & (bpm_in != 16'd0);
    assign start  = (main_q == STOPPED) & (div_q == DIV_PEND);
    assign beat   = (main_q == RUNNING) & tick & (scnt_q == 32'd0) & ~stop;
    assign commit = start | (beat & (div_q == DIV_PEND));
    assign iv     = commit ? res_q : ival_q;

    assign bpm_c = (bpm_in < 16'(MIN_BPM)) ? 16'(MIN_BPM) :
                   (bpm_in > 16'(MAX_BPM)) ? 16'(MAX_BPM) : bpm_in;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_sh = {rem_q, dq_q[31]};
    assign ge     = rem_sh >= {1'b0, dsr_q};
    assign rem_n  = ge ? 16'(rem_sh - {1'b0, dsr_q}) : rem_sh[15:0];
    assign dq_n   = {dq_q[30:0], ge};

    assign env_dec = env_q - (env_q >> 4);
    assign kn      = kcnt_q + KW'(1);

`ifdef BEAT_ACCENT_EN
    assign amp = (nxt_q == 4'd0) ? AMP_HI : AMP_LO;
`else
    assign amp = AMP_LO;
`endif

    always_comb begin
        div_d  = div_q;
        main_d = main_q;
        dq_d   = dq_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        dcnt_d = dcnt_q;
        res_d  = res_q;
        ival_d = ival_q;
        scnt_d = scnt_q;
        nxt_d  = nxt_q;
        bcnt_d = bcnt_q;
        beat_d = beat;
        env_d  = env_q;
        smp_d  = smp_q;
        kcnt_d = kcnt_q;
        act_d  = act_q;

        unique case (div_q)
            DIV_IDLE: if (load) begin
                div_d  = DIV_BUSY;
                dq_d   = DIVIDEND;
                rem_d  = '0;
                dsr_d  = bpm_c;
                dcnt_d = '0;
            end
            DIV_BUSY: begin
                dq_d   = dq_n;
                rem_d  = rem_n;
                dcnt_d = dcnt_q + 5'd1;
                if (dcnt_q == 5'd31) begin
                    div_d = DIV_PEND;
                    res_d = dq_n;
                end
            end
            DIV_PEND: if (commit) begin
                div_d  = DIV_IDLE;
                ival_d = res_q;
            end
            default: div_d = DIV_IDLE;
        endcase

        if (stop) begin
            main_d = STOPPED;
            scnt_d = '0;
            nxt_d  = '0;
            bcnt_d = '0;
            env_d  = '0;
            smp_d  = '0;
            kcnt_d = '0;
            act_d  = 1'b0;
        end else begin
            unique case (main_q)
                STOPPED: if (start) begin
                    main_d = RUNNING;
                    scnt_d = '0;
                    nxt_d  = '0;
                    bcnt_d = '0;
                end
                RUNNING: if (tick) begin
                    scnt_d = (scnt_q + 32'd1 >= iv) ? 32'd0 : scnt_q + 32'd1;
                    if (beat) begin
                        bcnt_d = nxt_q;
                        nxt_d  = (nxt_q == 4'(BEATS_PER_BAR - 1)) ? 4'd0 : nxt_q + 4'd1;
                        env_d  = amp;
                        smp_d  = amp;
                        kcnt_d = '0;
                        act_d  = 1'b1;
                    end else if (act_q) begin
                        if (kn < KW'(CLICK_SAMPLES)) begin
                            env_d  = env_dec;
                            smp_d  = kn[2] ? ({W{1'b0}} - env_dec) : env_dec;
                            kcnt_d = kn;
                        end else begin
                            env_d  = '0;
                            smp_d  = '0;
                            kcnt_d = '0;
                            act_d  = 1'b0;
                        end
                    end
                end
                default: main_d = STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= DIV_IDLE;
            main_q <= STOPPED;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            dq_q   <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            dcnt_q <= '0;
            res_q  <= '0;
            ival_q <= '0;
            scnt_q <= '0;
            nxt_q  <= '0;
            bcnt_q <= '0;
            beat_q <= 1'b0;
            env_q  <= '0;
            smp_q  <= '0;
            kcnt_q <= '0;
            act_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            main_q <= main_d;
            s1_q   <= sample_tick;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            dcnt_q <= dcnt_d;
            res_q  <= res_d;
            ival_q <= ival_d;
            scnt_q <= scnt_d;
            nxt_q  <= nxt_d;
            bcnt_q <= bcnt_d;
            beat_q <= beat_d;
            env_q  <= env_d;
            smp_q  <= smp_d;
            kcnt_q <= kcnt_d;
            act_q  <= act_d;
        end
    end

    assign bpm_ready    = (div_q == DIV_IDLE);
    assign running      = (main_q == RUNNING);
    assign beat_pulse   = beat_q;
    assign beat_count   = bcnt_q;
    assign click_sample = $signed(smp_q);
endmodule

// File: tb/tb_beat_click_generator.sv
// Directed bench for beat_click_generator at a reduced sample rate
// (SAMPLE_FREQ=400, click still 240 ticks) so each scenario stays short.
module tb_beat_click_generator;
    localparam int W      = 16;
    localparam int SF     = 400;
    localparam int CMS    = 600;
    localparam int CS     = SF * CMS / 1000;
    localparam int AMP_LO = 1 << (W - 2);
`ifdef BEAT_ACCENT_EN
    localparam int AMP_DB = (1 << (W - 1)) - 1;
`else
    localparam int AMP_DB = AMP_LO;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                sample_tick = 1'b0;
    logic [15:0]         bpm_in = 16'd0;
    logic                bpm_valid = 1'b0;
    logic                bpm_ready;
    logic                beat_pulse;
    logic [3:0]          beat_count;
    logic signed [W-1:0] click_sample;
    logic                running;

    int n_checks = 0;
    int n_err = 0;
    int tick_num = 0;
    int beat_t[$];
    int beat_c[$];
    int smp_log[0:16383];

    beat_click_generator #(
        .W(W), .SAMPLE_FREQ(SF), .CLICK_MS(CMS),
        .MIN_BPM(30), .MAX_BPM(300), .BEATS_PER_BAR(4)
    ) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .bpm_in(bpm_in), .bpm_valid(bpm_valid), .bpm_ready(bpm_ready),
        .beat_pulse(beat_pulse), .beat_count(beat_count),
        .click_sample(click_sample), .running(running)
    );

    always #5 clk = ~clk;

    // Sample strobe every 4 clk; the DUT reacts 3 clk after the raise.
    initial begin
        forever begin
            @(negedge clk);
            sample_tick = 1'b1;
            tick_num++;
            @(negedge clk);
            @(negedge clk);
            sample_tick = 1'b0;
            @(negedge clk);
            smp_log[tick_num % 16384] = int'(click_sample);
        end
    end

    always @(negedge clk) begin
        if (beat_pulse) begin
            beat_t.push_back(tick_num);
            beat_c.push_back(int'(beat_count));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bt(input int i);
        return (i < beat_t.size()) ? beat_t[i] : -100000;
    endfunction

    function automatic int bc(input int i);
        return (i < beat_c.size()) ? beat_c[i] : -1;
    endfunction

    function automatic int slog(input int t);
        return (t >= 0) ? smp_log[t % 16384] : -99999;
    endfunction

    task automatic load(input int v);
        int c = 0;
        while (!bpm_ready && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("load_ready", int'(bpm_ready), 1);
        bpm_in = 16'(v);
        bpm_valid = 1'b1;
        @(negedge clk);
        bpm_valid = 1'b0;
    endtask

    task automatic stop_chk(input string tag);
        load(0);
        check({tag, "_run"}, int'(running), 0);
        check({tag, "_smp"}, int'(click_sample), 0);
        check({tag, "_cnt"}, int'(beat_count), 0);
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int c = 0;
        while (beat_t.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_timeout"}, int'(beat_t.size() >= n), 1);
    endtask

    task automatic wait_tick(input int t, input string tag);
        int c = 0;
        while (tick_num < t && c < 8000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_timeout"}, int'(tick_num >= t), 1);
    endtask

    initial begin
        int c;
        int t0;
        int b0;
        int n;
        int a1;

        repeat (3) @(negedge clk);
        check("rst_pulse", int'(beat_pulse), 0);
        check("rst_count", int'(beat_count), 0);
        check("rst_click", int'(click_sample), 0);
        check("rst_running", int'(running), 0);
        check("rst_ready", int'(bpm_ready), 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 120 BPM -> 200 ticks per beat
        load(120);
        c = 0;
        while (!bpm_ready && c < 200) begin
            c++;
            @(negedge clk);
        end
        check("ready_low_33", int'(c >= 33 && c < 200), 1);
        check("run_120", int'(running), 1);
        beat_t.delete();
        beat_c.delete();
        t0 = tick_num;
        wait_beats(5, 5000, "b120");
        check("first_beat", int'(bt(0) - t0 >= 0 && bt(0) - t0 <= 1), 1);
        for (int i = 1; i < 5; i++)
            check("gap120", bt(i) - bt(i - 1), 200);
        for (int i = 0; i < 5; i++)
            check("bar_pos", bc(i), i % 4);

        // clamp high: 400 -> 300 BPM -> 80 ticks
        stop_chk("stop1");
        beat_t.delete();
        beat_c.delete();
        load(400);
        wait_beats(3, 2000, "b300");
        check("gap300_a", bt(1) - bt(0), 80);
        check("gap300_b", bt(2) - bt(1), 80);
        check("restart_amp", slog(bt(1)), AMP_LO);
        check("restart_pos", bc(1), 1);

        // clamp low: 10 -> 30 BPM -> 800 ticks
        stop_chk("stop2");
        beat_t.delete();
        beat_c.delete();
        load(10);
        wait_beats(2, 5000, "b30");
        check("gap30", bt(1) - bt(0), 800);

        // retime while running: pending tempo waits for the beat
        stop_chk("stop3");
        beat_t.delete();
        beat_c.delete();
        load(120);
        wait_beats(1, 2000, "r1");
        b0 = bt(0);
        wait_tick(b0 + 100, "r_load");
        load(240);
        wait_tick(b0 + 150, "r_mid");
        check("pend_ready", int'(bpm_ready), 0);
        wait_beats(4, 3000, "r4");
        check("r_gap1", bt(1) - bt(0), 200);
        check("r_gap2", bt(2) - bt(1), 100);
        check("r_gap3", bt(3) - bt(2), 100);
        check("r_ready", int'(bpm_ready), 1);

        // click shape at 30 BPM
        stop_chk("stop4");
        beat_t.delete();
        beat_c.delete();
        load(30);
        wait_beats(1, 2000, "c1");
        b0 = bt(0);
        check("c_pos0", bc(0), 0);
        wait_tick(b0 + CS + 3, "c_end");
        a1 = AMP_DB - (AMP_DB >> 4);
        check("c_first", slog(b0), AMP_DB);
        check("c_decay1", slog(b0 + 1), a1);
        check("c_pos_t3", int'(slog(b0 + 3) > 0), 1);
        check("c_neg_t4", int'(slog(b0 + 4) < 0), 1);
        check("c_neg_t7", int'(slog(b0 + 7) < 0), 1);
        check("c_pos_t8", int'(slog(b0 + 8) > 0), 1);
        check("c_live_239", int'(slog(b0 + CS - 1) < 0), 1);
        check("c_zero_240", slog(b0 + CS), 0);
        check("c_zero_241", slog(b0 + CS + 1), 0);
        wait_beats(2, 4000, "c2");
        check("c_gap", bt(1) - bt(0), 800);
        check("c_pos1", bc(1), 1);
        wait_tick(bt(1) + 12, "c_mid");
        check("c_amp2", slog(bt(1)), AMP_LO);
        check("c_active", int'(click_sample != 0), 1);

        // stop in the middle of a click
        stop_chk("stop_mid");
        n = beat_t.size();
        repeat (1200) @(negedge clk);
        check("stop_nobeat", beat_t.size(), n);
        check("stop_run", int'(running), 0);
        check("stop_click", int'(click_sample), 0);

        // reset during an active divide
        load(120);
        repeat (10) @(negedge clk);
        check("busy_ready", int'(bpm_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_ready", int'(bpm_ready), 1);
        check("mr_run", int'(running), 0);
        check("mr_pulse", int'(beat_pulse), 0);
        check("mr_count", int'(beat_count), 0);
        check("mr_click", int'(click_sample), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = beat_t.size();
        repeat (2000) @(negedge clk);
        check("pr_nobeat", beat_t.size(), n);
        check("pr_run", int'(running), 0);
        check("pr_ready", int'(bpm_ready), 1);
        check("pr_click", int'(click_sample), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
